// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tag for the OoO core.
// Issue marks a destination busy with its RoB tag; commit retires values and frees matching tags.
module reg_file_rename #(
  parameter int unsigned ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               val1,
  output logic [31:0]               val2,
  output logic                      dep1,
  output logic                      dep2,
  output logic [ROB_SIZE_WIDTH-1:0] tag1,
  output logic [ROB_SIZE_WIDTH-1:0] tag2,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
  input  logic                      get_ready1,
  input  logic                      get_ready2,
  input  logic [31:0]               get_value1,
  input  logic [31:0]               get_value2
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned TW   = ROB_SIZE_WIDTH;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            dep;
    logic [TW-1:0]   tag;
  } lookup_t;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [TW-1:0]   tag_q  [NREG];
  logic [TW-1:0]   tag_d  [NREG];

  logic            issue_en;
  logic            commit_en;
  lookup_t         lk1, lk2;

  assign issue_en  = rdy && !clear && (issue_rd != 5'd0);
  assign commit_en = rdy && (commit_rd != 5'd0);

  // Next-state: commit first, then clear or issue so issue wins on the same rd.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_en) begin
      regs_d[commit_rd] = commit_value;
      if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (rdy && clear) begin
      busy_d = '0;
      for (int i = 0; i < NREG; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_en) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  // Operand resolution: regfile, then same-cycle commit, then RoB forward, else wait on tag.
  function automatic lookup_t lookup(
    input logic [4:0]      rs,
    input logic            busy,
    input logic [TW-1:0]   tag,
    input logic [XLEN-1:0] regv,
    input logic            fwd_ready,
    input logic [XLEN-1:0] fwd_value
  );
    lookup_t r;
    r = '0;
    if (rs == 5'd0) begin
      r.val = '0;
    end else if (!busy) begin
      r.val = regv;
    end else if (commit_en && (commit_rd == rs) && (commit_rob_id == tag)) begin
      r.val = commit_value;
    end else if (fwd_ready) begin
      r.val = fwd_value;
    end else begin
      r.dep = 1'b1;
      r.tag = tag;
    end
    return r;
  endfunction

  always_comb begin
    lk1 = lookup(rs1, busy_q[rs1], tag_q[rs1], regs_q[rs1], get_ready1, get_value1);
    lk2 = lookup(rs2, busy_q[rs2], tag_q[rs2], regs_q[rs2], get_ready2, get_value2);
  end

  assign val1        = lk1.val;
  assign dep1        = lk1.dep;
  assign tag1        = lk1.tag;
  assign val2        = lk2.val;
  assign dep2        = lk2.dep;
  assign tag2        = lk2.tag;
  assign get_rob_id1 = tag_q[rs1];
  assign get_rob_id2 = tag_q[rs2];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: issue/commit/clear/rdy/reset with hand-computed lookups.
module tb_reg_file_rename;

  localparam int unsigned W = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic [4:0]    issue_rd, commit_rd, rs1, rs2;
  logic [W-1:0]  issue_rob_id, commit_rob_id;
  logic [31:0]   commit_value, get_value1, get_value2;
  logic          get_ready1, get_ready2;
  logic [31:0]   val1, val2;
  logic          dep1, dep2;
  logic [W-1:0]  tag1, tag2, get_rob_id1, get_rob_id2;

  int n_cmp = 0;
  int n_mis = 0;

  reg_file_rename #(.ROB_SIZE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2), .tag1(tag1), .tag2(tag2),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .get_value1(get_value1), .get_value2(get_value2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_rd = 5'd0; issue_rob_id = '0;
    commit_rd = 5'd0; commit_rob_id = '0; commit_value = '0;
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; idle();
    rs1 = 5'd0; rs2 = 5'd0;
    get_ready1 = 1'b0; get_ready2 = 1'b0; get_value1 = '0; get_value2 = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd0; #1;
    check("rst_val1", val1, 32'h0);
    check("rst_dep1", 32'(dep1), 32'h0);
    check("rst_val2", val2, 32'h0);
    check("rst_dep2", 32'(dep2), 32'h0);
    check("rst_tag1", 32'(tag1), 32'h0);
    check("rst_getid1", 32'(get_rob_id1), 32'h0);

    // Issue x5 tag 3, then wait / forward from RoB
    issue_rd = 5'd5; issue_rob_id = 4'd3;
    #1 check("own_rd_old_map", 32'(dep1), 32'h0);
    step(); idle();
    #1;
    check("iss_dep1", 32'(dep1), 32'h1);
    check("iss_tag1", 32'(tag1), 32'h3);
    check("iss_getid1", 32'(get_rob_id1), 32'h3);
    check("iss_val1", val1, 32'h0);
    get_ready1 = 1'b1; get_value1 = 32'h1234; #1;
    check("fwd_dep1", 32'(dep1), 32'h0);
    check("fwd_val1", val1, 32'h1234);
    check("fwd_tag1", 32'(tag1), 32'h0);
    get_ready1 = 1'b0; get_value1 = '0;

    // Same-cycle commit bypass, then retired state
    commit_rd = 5'd5; commit_rob_id = 4'd3; commit_value = 32'hDEAD; #1;
    check("byp_val1", val1, 32'hDEAD);
    check("byp_dep1", 32'(dep1), 32'h0);
    step(); idle(); #1;
    check("ret_dep1", 32'(dep1), 32'h0);
    check("ret_val1", val1, 32'hDEAD);

    // Stale commit keeps newer mapping
    rs1 = 5'd7;
    issue_rd = 5'd7; issue_rob_id = 4'd2; step();
    issue_rd = 5'd7; issue_rob_id = 4'd4; step(); idle();
    commit_rd = 5'd7; commit_rob_id = 4'd2; commit_value = 32'd9; #1;
    check("stale_byp_dep1", 32'(dep1), 32'h1);
    step(); idle(); #1;
    check("stale_dep1", 32'(dep1), 32'h1);
    check("stale_tag1", 32'(tag1), 32'h4);

    // Matching commit plus same-cycle reissue: issue wins
    commit_rd = 5'd7; commit_rob_id = 4'd4; commit_value = 32'h77;
    issue_rd = 5'd7; issue_rob_id = 4'd6; #1;
    check("reiss_byp_val1", val1, 32'h77);
    step(); idle(); #1;
    check("reiss_dep1", 32'(dep1), 32'h1);
    check("reiss_tag1", 32'(tag1), 32'h6);
    get_ready1 = 1'b1; get_value1 = 32'hABC; #1;
    check("reiss_fwd_val1", val1, 32'hABC);
    get_ready1 = 1'b0; get_value1 = '0;

    // Clear with same-cycle commit and discarded issue
    issue_rd = 5'd3; issue_rob_id = 4'd1; step();
    issue_rd = 5'd4; issue_rob_id = 4'd2; step(); idle();
    rs1 = 5'd3; rs2 = 5'd4; #1;
    check("pre_clr_dep1", 32'(dep1), 32'h1);
    check("pre_clr_tag2", 32'(tag2), 32'h2);
    clear = 1'b1; commit_rd = 5'd9; commit_rob_id = 4'd0; commit_value = 32'h55;
    issue_rd = 5'd10; issue_rob_id = 4'd5;
    step(); idle(); #1;
    check("clr_dep1", 32'(dep1), 32'h0);
    check("clr_dep2", 32'(dep2), 32'h0);
    check("clr_val1", val1, 32'h0);
    rs1 = 5'd9; rs2 = 5'd10; #1;
    check("clr_commit_val", val1, 32'h55);
    check("clr_x10_dep", 32'(dep2), 32'h0);
    rs1 = 5'd7; #1;
    check("x7_after_clr", val1, 32'h77);
    check("x7_dep_after_clr", 32'(dep1), 32'h0);

    // x0 is never written or busy
    issue_rd = 5'd0; issue_rob_id = 4'd5;
    commit_rd = 5'd0; commit_value = 32'hFFFF;
    step(); idle();
    rs1 = 5'd0; rs2 = 5'd5; #1;
    check("x0_val", val1, 32'h0);
    check("x0_dep", 32'(dep1), 32'h0);
    check("x5_kept", val2, 32'hDEAD);

    // rdy=0 holds state and disables bypass
    issue_rd = 5'd6; issue_rob_id = 4'd1; step(); idle();
    rs1 = 5'd6;
    rdy = 1'b0;
    commit_rd = 5'd6; commit_rob_id = 4'd1; commit_value = 32'd1;
    issue_rd = 5'd6; issue_rob_id = 4'd2; #1;
    check("rdy0_nobyp_dep1", 32'(dep1), 32'h1);
    check("rdy0_tag1", 32'(tag1), 32'h1);
    step(); idle(); rdy = 1'b1; #1;
    check("rdy0_hold_dep1", 32'(dep1), 32'h1);
    check("rdy0_hold_tag1", 32'(tag1), 32'h1);

    // Reset mid-operation
    rst = 1'b1; step(); rst = 1'b0;
    rs1 = 5'd5; rs2 = 5'd6; #1;
    check("rst2_val1", val1, 32'h0);
    check("rst2_dep2", 32'(dep2), 32'h0);
    check("rst2_val2", val2, 32'h0);
    check("rst2_getid2", 32'(get_rob_id2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
